// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and constants for the stack/memory controller:
//   op_e       : EX/MEM operation codes carried on the 3-bit op port
//   state_e    : controller FSM states (IDLE, SECOND for two-word CALL/RET)
//   sp_delta_e : stack-pointer update selector used by sp_unit
//   SP_RESET   : reset value of the stack pointer (all ones = top of memory)
//   decode_op  : folds req_valid and unknown codes into OP_NONE
// -----------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_PUSH  = 3'd3,
    OP_POP   = 3'd4,
    OP_CALL  = 3'd5,
    OP_RET   = 3'd6
  } op_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    SP_HOLD = 3'd0,
    SP_INC1 = 3'd1,
    SP_DEC1 = 3'd2,
    SP_INC2 = 3'd3,
    SP_DEC2 = 3'd4
  } sp_delta_e;

  // All ones; users slice it to ADDR_SIZE so the stack starts at the top word.
  localparam logic [31:0] SP_RESET = 32'hFFFF_FFFF;

  // A request without req_valid, or with an unassigned code, is a no-op.
  function automatic op_e decode_op(input logic valid, input logic [2:0] code);
    if (!valid || code > 3'd6) return OP_NONE;
    return op_e'(code);
  endfunction

endpackage

// File: rtl/sp_unit.sv
// -----------------------------------------------------------------------------
// sp_unit
// Stack-pointer register with +1/-1/+2/-2 update and bound check.
// The stack grows downward from the top address; arithmetic is modulo
// 2^ADDR_SIZE.
// Build option: STACK_CHECK_EN -- when defined, bound_err flags a requested
// move that would cross below address 0 or above the top address; when
// undefined, bound_err is tied low and the pointer wraps silently.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (sp -> top address)
//   delta      : requested move (sp_delta_e encoding), also the move checked
//   upd        : apply delta at the next posedge
//   sp         : current stack pointer
//   bound_err  : the requested move would cross a memory boundary
// -----------------------------------------------------------------------------
module sp_unit
  import mem_pkg::*;
#(
  parameter int ADDR_SIZE = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           delta,
  input  logic                 upd,
  output logic [ADDR_SIZE-1:0] sp,
  output logic                 bound_err
);

  localparam logic [ADDR_SIZE-1:0] SP_TOP = SP_RESET[ADDR_SIZE-1:0];

  logic [ADDR_SIZE-1:0] sp_next;

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned -- that is what keeps latches from being inferred.
  always_comb begin
    sp_next = sp;
    case (delta)
      SP_INC1: sp_next = sp + ADDR_SIZE'(1);
      SP_DEC1: sp_next = sp - ADDR_SIZE'(1);
      SP_INC2: sp_next = sp + ADDR_SIZE'(2);
      SP_DEC2: sp_next = sp - ADDR_SIZE'(2);
      default: sp_next = sp;
    endcase
  end

`ifdef STACK_CHECK_EN
  always_comb begin
    bound_err = 1'b0;
    case (delta)
      SP_DEC1: bound_err = (sp == '0);
      SP_DEC2: bound_err = (sp < ADDR_SIZE'(2));
      SP_INC1: bound_err = (sp == SP_TOP);
      SP_INC2: bound_err = (sp >= SP_TOP - ADDR_SIZE'(1));
      default: bound_err = 1'b0;
    endcase
  end
`else
  assign bound_err = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      sp <= SP_TOP;
    else if (upd) sp <= sp_next;
  end

endmodule

// File: rtl/stack_mem_ctrl.sv
// -----------------------------------------------------------------------------
// stack_mem_ctrl
// MEM-stage controller translating LOAD/STORE/PUSH/POP/CALL/RET requests into
// single-port data-memory accesses. The memory completes each access at the
// negedge of the cycle the strobe is driven, so read data is registered at the
// following posedge. CALL/RET move a two-word PC and take two cycles (stall
// high during the first).
// Build option: STACK_CHECK_EN -- enables stack bound checking and the sticky
// stack_err flag; without it the stack pointer wraps and stack_err is 0.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid, op       : request strobe and op code (mem_pkg::op_e)
//   ea, wdata, pc_in    : LOAD/STORE address, STORE/PUSH data, CALL return PC
//   mem_rd              : data-memory read data
//   mem_read, mem_write : data-memory strobes (mutually exclusive)
//   mem_addr, mem_wd    : data-memory address and write data
//   stall               : hold request to upstream
//   rdata, rdata_valid  : LOAD/POP result and one-cycle valid pulse
//   pc_out, pc_valid    : RET target and one-cycle valid pulse
//   sp, stack_err       : stack pointer and sticky stack fault
// -----------------------------------------------------------------------------
module stack_mem_ctrl
  import mem_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 11,
  parameter int PC_SIZE   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [2:0]           op,
  input  logic [ADDR_SIZE-1:0] ea,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic [PC_SIZE-1:0]   pc_in,
  input  logic [WORD_SIZE-1:0] mem_rd,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wd,
  output logic                 stall,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 rdata_valid,
  output logic [PC_SIZE-1:0]   pc_out,
  output logic                 pc_valid,
  output logic [ADDR_SIZE-1:0] sp,
  output logic                 stack_err
);

  state_e               state_q, state_d;
  op_e                  cur_op, latched_op_q;
  logic [WORD_SIZE-1:0] hold_q;      // CALL: low PC word; RET: low word read
  logic [2:0]           sp_delta;
  logic                 sp_upd, bound_err;
  logic                 rd_cap, pc_cap, hold_cap;

  // rst gates the request so no strobe escapes while reset is held.
  assign cur_op = rst ? OP_NONE : decode_op(req_valid, op);

  sp_unit #(.ADDR_SIZE(ADDR_SIZE)) u_sp (
    .clk       (clk),
    .rst       (rst),
    .delta     (sp_delta),
    .upd       (sp_upd),
    .sp        (sp),
    .bound_err (bound_err)
  );

  // Kept apart from the main decode so bound_err never loops back into the
  // block that selects the move being checked.
  always_comb begin
    sp_delta = SP_HOLD;
    if (state_q == ST_SECOND) begin
      sp_delta = (latched_op_q == OP_CALL) ? SP_DEC2 : SP_INC2;
    end else begin
      case (cur_op)
        OP_PUSH: sp_delta = SP_DEC1;
        OP_POP:  sp_delta = SP_INC1;
        OP_CALL: sp_delta = SP_DEC2;
        OP_RET:  sp_delta = SP_INC2;
        default: sp_delta = SP_HOLD;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = ea;
    mem_wd    = wdata;
    stall     = 1'b0;
    sp_upd    = 1'b0;
    rd_cap    = 1'b0;
    pc_cap    = 1'b0;
    hold_cap  = 1'b0;
    if (!rst) begin
      if (state_q == ST_IDLE) begin
        case (cur_op)
          OP_LOAD: begin
            mem_read = 1'b1;
            rd_cap   = 1'b1;
          end
          OP_STORE: mem_write = 1'b1;
          OP_PUSH: if (!bound_err) begin
            mem_write = 1'b1;
            mem_addr  = sp;
            sp_upd    = 1'b1;
          end
          OP_POP: if (!bound_err) begin
            mem_read = 1'b1;
            mem_addr = sp + ADDR_SIZE'(1);
            sp_upd   = 1'b1;
            rd_cap   = 1'b1;
          end
          OP_CALL: if (!bound_err) begin
            mem_write = 1'b1;
            mem_addr  = sp;
            mem_wd    = pc_in[PC_SIZE-1 -: WORD_SIZE];
            stall     = 1'b1;
            hold_cap  = 1'b1;
            state_d   = ST_SECOND;
          end
          OP_RET: if (!bound_err) begin
            mem_read = 1'b1;
            mem_addr = sp + ADDR_SIZE'(1);
            stall    = 1'b1;
            hold_cap = 1'b1;
            state_d  = ST_SECOND;
          end
          default: ;
        endcase
      end else begin
        // Second word of CALL/RET; new requests are ignored until it retires.
        state_d = ST_IDLE;
        sp_upd  = 1'b1;
        if (latched_op_q == OP_CALL) begin
          mem_write = 1'b1;
          mem_addr  = sp - ADDR_SIZE'(1);
          mem_wd    = hold_q;
        end else begin
          mem_read = 1'b1;
          mem_addr = sp + ADDR_SIZE'(2);
          pc_cap   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      latched_op_q <= OP_NONE;
      hold_q       <= '0;
      rdata        <= '0;
      rdata_valid  <= 1'b0;
      pc_out       <= '0;
      pc_valid     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdata_valid <= rd_cap;
      pc_valid    <= pc_cap;
      if (hold_cap) begin
        latched_op_q <= cur_op;
        hold_q       <= (cur_op == OP_CALL) ? pc_in[WORD_SIZE-1:0] : mem_rd;
      end
      if (rd_cap) rdata  <= mem_rd;
      if (pc_cap) pc_out <= {mem_rd, hold_q};
    end
  end

`ifdef STACK_CHECK_EN
  // bound_err is only raised by a rejected stack op in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            stack_err <= 1'b0;
    else if (bound_err) stack_err <= 1'b1;
  end
`else
  assign stack_err = 1'b0;
`endif

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stack_mem_ctrl
// Self-checking bench for stack_mem_ctrl. A memory fixture answers the DUT at
// each negedge; a transaction-level model (stack pointer, expected memory
// image, expected bus activity per op) is compared against every DUT output
// on every negedge. Works with and without STACK_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_stack_mem_ctrl;

  localparam int WS = 16;
  localparam int AS = 11;
  localparam int PS = 32;
  localparam logic [AS-1:0] TOP = 11'h7FF;
`ifdef STACK_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam logic [2:0] C_NONE = 3'd0, C_LOAD = 3'd1, C_STORE = 3'd2, C_PUSH = 3'd3,
                         C_POP = 3'd4, C_CALL = 3'd5, C_RET = 3'd6;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [2:0]    op;
  logic [AS-1:0] ea;
  logic [WS-1:0] wdata;
  logic [PS-1:0] pc_in;
  logic [WS-1:0] mem_rd;
  logic          mem_read, mem_write, stall, rdata_valid, pc_valid, stack_err;
  logic [AS-1:0] mem_addr, sp;
  logic [WS-1:0] mem_wd, rdata;
  logic [PS-1:0] pc_out;

  always #5 clk = ~clk;

  stack_mem_ctrl #(.WORD_SIZE(WS), .ADDR_SIZE(AS), .PC_SIZE(PS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .op(op), .ea(ea), .wdata(wdata),
    .pc_in(pc_in), .mem_rd(mem_rd), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .stall(stall), .rdata(rdata),
    .rdata_valid(rdata_valid), .pc_out(pc_out), .pc_valid(pc_valid), .sp(sp),
    .stack_err(stack_err)
  );

  // Memory fixture: completes the strobed access at the negedge.
  logic [WS-1:0] fmem [0:2047];
  always @(negedge clk) begin
    if (mem_write) fmem[mem_addr] <= mem_wd;
    if (mem_read)  mem_rd <= fmem[mem_addr];
  end

  // Reference model state and per-cycle expectations.
  logic [WS-1:0] m_mem [0:2047];
  logic [AS-1:0] m_sp;
  logic          e_read, e_write, e_stall, e_rv, e_pv, e_err;
  logic [AS-1:0] e_addr;
  logic [WS-1:0] e_wd, e_rdata;
  logic [PS-1:0] e_pc;
  bit            chk_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_read", 32'(mem_read), 32'(e_read));
      check("mem_write", 32'(mem_write), 32'(e_write));
      if (e_read || e_write) check("mem_addr", 32'(mem_addr), 32'(e_addr));
      if (e_write) check("mem_wd", 32'(mem_wd), 32'(e_wd));
      check("stall", 32'(stall), 32'(e_stall));
      check("rdata_valid", 32'(rdata_valid), 32'(e_rv));
      check("rdata", 32'(rdata), 32'(e_rdata));
      check("pc_valid", 32'(pc_valid), 32'(e_pv));
      check("pc_out", pc_out, e_pc);
      check("sp", 32'(sp), 32'(m_sp));
      check("stack_err", 32'(stack_err), 32'(e_err));
    end
  end

  // One clock of stimulus with the bus activity expected in that cycle.
  task automatic cyc(input logic v, input logic [2:0] o, input logic [AS-1:0] a,
                     input logic [WS-1:0] d, input logic [PS-1:0] p,
                     input logic er, input logic ew, input logic [AS-1:0] eaddr,
                     input logic [WS-1:0] ewd, input logic est);
    req_valid = v; op = o; ea = a; wdata = d; pc_in = p;
    e_read = er; e_write = ew; e_addr = eaddr; e_wd = ewd; e_stall = est;
    @(posedge clk); #1;
    e_rv = 1'b0; e_pv = 1'b0;
  endtask

  task automatic do_idle();
    cyc(1'b0, C_NONE, 11'h000, 16'h0000, 32'h0, 1'b0, 1'b0, 11'h000, 16'h0000, 1'b0);
  endtask

  task automatic do_store(input logic [AS-1:0] a, input logic [WS-1:0] d);
    cyc(1'b1, C_STORE, a, d, 32'hDEAD_0000, 1'b0, 1'b1, a, d, 1'b0);
    m_mem[a] = d;
  endtask

  task automatic do_load(input logic [AS-1:0] a);
    cyc(1'b1, C_LOAD, a, 16'h1111, 32'h0, 1'b1, 1'b0, a, 16'h0000, 1'b0);
    e_rv = 1'b1; e_rdata = m_mem[a];
  endtask

  task automatic do_push(input logic [WS-1:0] d);
    if (CHK && m_sp == 11'd0) begin
      cyc(1'b1, C_PUSH, 11'h3C3, d, 32'h0, 1'b0, 1'b0, 11'h000, 16'h0000, 1'b0);
      e_err = 1'b1;
    end else begin
      cyc(1'b1, C_PUSH, 11'h3C3, d, 32'h0, 1'b0, 1'b1, m_sp, d, 1'b0);
      m_mem[m_sp] = d;
      m_sp = m_sp - 11'd1;
    end
  endtask

  task automatic do_pop();
    logic [AS-1:0] a;
    if (CHK && m_sp == TOP) begin
      cyc(1'b1, C_POP, 11'h3C3, 16'h0000, 32'h0, 1'b0, 1'b0, 11'h000, 16'h0000, 1'b0);
      e_err = 1'b1;
    end else begin
      a = m_sp + 11'd1;
      cyc(1'b1, C_POP, 11'h3C3, 16'h0000, 32'h0, 1'b1, 1'b0, a, 16'h0000, 1'b0);
      e_rv = 1'b1; e_rdata = m_mem[a];
      m_sp = a;
    end
  endtask

  // garble: second-cycle inputs are changed to prove they are ignored.
  task automatic do_call(input logic [PS-1:0] p, input bit garble);
    logic [AS-1:0] lo_a;
    if (CHK && m_sp < 11'd2) begin
      cyc(1'b1, C_CALL, 11'h3C3, 16'h7777, p, 1'b0, 1'b0, 11'h000, 16'h0000, 1'b0);
      e_err = 1'b1;
    end else begin
      lo_a = m_sp - 11'd1;
      cyc(1'b1, C_CALL, 11'h3C3, 16'h7777, p, 1'b0, 1'b1, m_sp, p[31:16], 1'b1);
      m_mem[m_sp] = p[31:16];
      if (garble)
        cyc(1'b0, C_PUSH, 11'h155, 16'h9999, 32'hFFFF_FFFF, 1'b0, 1'b1, lo_a, p[15:0], 1'b0);
      else
        cyc(1'b1, C_CALL, 11'h3C3, 16'h7777, p, 1'b0, 1'b1, lo_a, p[15:0], 1'b0);
      m_mem[lo_a] = p[15:0];
      m_sp = m_sp - 11'd2;
    end
  endtask

  task automatic do_ret(input bit garble);
    logic [AS-1:0] lo_a, hi_a;
    if (CHK && m_sp >= TOP - 11'd1) begin
      cyc(1'b1, C_RET, 11'h3C3, 16'h0000, 32'h0, 1'b0, 1'b0, 11'h000, 16'h0000, 1'b0);
      e_err = 1'b1;
    end else begin
      lo_a = m_sp + 11'd1;
      hi_a = m_sp + 11'd2;
      cyc(1'b1, C_RET, 11'h3C3, 16'h0000, 32'h0, 1'b1, 1'b0, lo_a, 16'h0000, 1'b1);
      if (garble)
        cyc(1'b1, C_STORE, 11'h155, 16'h9999, 32'h0, 1'b1, 1'b0, hi_a, 16'h0000, 1'b0);
      else
        cyc(1'b1, C_RET, 11'h3C3, 16'h0000, 32'h0, 1'b1, 1'b0, hi_a, 16'h0000, 1'b0);
      e_pv = 1'b1; e_pc = {m_mem[hi_a], m_mem[lo_a]};
      m_sp = hi_a;
    end
  endtask

  // Reset is raised with whatever request is on the inputs, to show it wins.
  task automatic do_reset();
    rst = 1'b1;
    e_read = 1'b0; e_write = 1'b0; e_stall = 1'b0; e_rv = 1'b0; e_pv = 1'b0;
    e_rdata = '0; e_pc = '0; e_err = 1'b0; m_sp = TOP;
    @(posedge clk); #1;
    req_valid = 1'b0; op = C_NONE;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; op = C_NONE; ea = '0; wdata = '0; pc_in = '0;
    mem_rd = '0;
    for (int i = 0; i < 2048; i++) begin
      fmem[i]  = 16'(i) ^ 16'h5A00;
      m_mem[i] = 16'(i) ^ 16'h5A00;
    end
    e_read = 1'b0; e_write = 1'b0; e_stall = 1'b0; e_rv = 1'b0; e_pv = 1'b0;
    e_rdata = '0; e_pc = '0; e_err = 1'b0; m_sp = TOP; e_addr = '0; e_wd = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("reset_sp_literal", 32'(sp), 32'h7FF);
    check("reset_pc_literal", pc_out, 32'h0);
    do_idle();

    // PUSH then POP round trip
    do_push(16'hBEEF);
    check("push_sp_literal", 32'(sp), 32'h7FE);
    do_pop();
    check("pop_rdata_literal", 32'(rdata), 32'hBEEF);
    check("pop_valid_literal", 32'(rdata_valid), 32'h1);
    check("push_mem_literal", 32'(fmem[11'h7FF]), 32'hBEEF);
    do_idle();

    // CALL / RET
    do_call(32'h1234_5678, 1'b0);
    check("call_sp_literal", 32'(sp), 32'h7FD);
    check("call_hi_literal", 32'(fmem[11'h7FF]), 32'h1234);
    check("call_lo_literal", 32'(fmem[11'h7FE]), 32'h5678);
    do_idle();
    do_ret(1'b0);
    check("ret_pc_literal", pc_out, 32'h1234_5678);
    check("ret_sp_literal", 32'(sp), 32'h7FF);
    do_idle();

    // STORE / LOAD
    do_store(11'h010, 16'hA5A5);
    do_load(11'h010);
    check("load_rdata_literal", 32'(rdata), 32'hA5A5);

    // Stack ordering, back to back
    do_push(16'h1111); do_push(16'h2222); do_push(16'h3333);
    do_pop(); do_pop(); do_pop();
    do_idle();

    // Second-cycle inputs ignored; nested push/call
    do_call(32'hABCD_0123, 1'b1);
    do_ret(1'b1);
    do_push(16'h4444);
    do_call(32'h5555_6666, 1'b0);
    do_ret(1'b0);
    do_pop();

    // No-op forms: unassigned code, and valid low with a real op
    cyc(1'b1, 3'd7, 11'h020, 16'hFFFF, 32'h0, 1'b0, 1'b0, 11'h000, 16'h0000, 1'b0);
    cyc(1'b0, C_STORE, 11'h020, 16'hFFFF, 32'h0, 1'b0, 1'b0, 11'h000, 16'h0000, 1'b0);
    do_store(11'h7A0, 16'h1357);
    do_load(11'h7A0);
    do_load(11'h010);
    do_idle();

    // Reset during CALL second cycle: low word never written, sp untouched
    cyc(1'b1, C_CALL, 11'h3C3, 16'h7777, 32'hCAFE_F00D, 1'b0, 1'b1, m_sp, 16'hCAFE, 1'b1);
    m_mem[m_sp] = 16'hCAFE;
    do_reset();
    do_idle();
    check("midcall_lo_literal", 32'(fmem[11'h7FE]), 32'h5555);
    check("midcall_sp_literal", 32'(sp), 32'h7FF);

    // POP straight after reset
    do_pop();
`ifdef STACK_CHECK_EN
    check("pop_err_literal", 32'(stack_err), 32'h1);
    check("pop_err_sp_literal", 32'(sp), 32'h7FF);
    do_idle();
    do_ret(1'b0);
    do_reset();
    // Fill to address 0, then PUSH and CALL must be refused
    for (int i = 0; i < 2047; i++) do_push(16'(i) ^ 16'h0F0F);
    check("fill_sp_literal", 32'(sp), 32'h000);
    do_push(16'hEEEE);
    do_call(32'h0BAD_0BAD, 1'b0);
    check("push_err_literal", 32'(stack_err), 32'h1);
    do_pop();
    do_reset();
`else
    check("pop_wrap_sp_literal", 32'(sp), 32'h000);
    check("pop_wrap_rdata_literal", 32'(rdata), 32'h5A00);
    do_push(16'hEEEE);
    check("push_wrap_sp_literal", 32'(sp), 32'h7FF);
`endif
    do_idle();
    do_idle();
    chk_en = 1'b0;

    // Final memory image against the model
    for (int i = 0; i < 2048; i++)
      check($sformatf("mem_image[%0h]", i), 32'(fmem[i]), 32'(m_mem[i]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stack_mem_ctrl.md
STACK_MEM_CTRL -- requirements
Module: stack_mem_ctrl

Interface
REQ-001 Params SHALL be: WORD_SIZE, default 16, data word width; ADDR_SIZE, default 11, data-memory address width; PC_SIZE, default 32, program-counter width (= 2 words).
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  EX/MEM request present; held stable by upstream while stall=1.
REQ-005 op  in  3  NONE=0, LOAD=1, STORE=2, PUSH=3, POP=4, CALL=5, RET=6.
REQ-006 ea  in  ADDR_SIZE  effective address for LOAD/STORE.
REQ-007 wdata  in  WORD_SIZE  STORE/PUSH data.
REQ-008 pc_in  in  PC_SIZE  return address for CALL.
REQ-009 mem_rd  in  WORD_SIZE  data-memory read port (updated on negedge).
REQ-010 mem_read, mem_write  out  1 each  data-memory strobes, never both high.
REQ-011 mem_addr  out  ADDR_SIZE; mem_wd  out  WORD_SIZE  data-memory address/write data.
REQ-012 stall  out  1  upstream hold request.
REQ-013 rdata  out  WORD_SIZE; rdata_valid  out  1  LOAD/POP result.
REQ-014 pc_out  out  PC_SIZE; pc_valid  out  1  RET target.
REQ-015 sp  out  ADDR_SIZE  current stack pointer; stack_err  out  1  sticky stack fault.

Function
REQ-016 FSM SHALL have states IDLE and SECOND; only CALL/RET enter SECOND.
REQ-017 mem_* SHALL be combinational from state, op, ea, sp; memory completes the access at the negedge of the same cycle.
REQ-018 LOAD: mem_read=1, addr=ea; rdata registered at next posedge, rdata_valid high one cycle.
REQ-019 STORE: mem_write=1, addr=ea, wd=wdata; single cycle.
REQ-020 PUSH: write wdata at sp, then sp <= sp-1 (descending, post-decrement).
REQ-021 POP: read at sp+1, sp <= sp+1; rdata/rdata_valid as LOAD.
REQ-022 CALL: cycle 1 write pc_in[31:16] at sp, stall=1; cycle 2 write pc_in[15:0] at sp-1, stall=0; sp <= sp-2 at end of cycle 2.
REQ-023 RET: cycle 1 read sp+1 (low word), stall=1, latch low; cycle 2 read sp+2 (high word), stall=0; pc_out={high,low}, pc_valid one cycle after cycle 2; sp <= sp+2.
REQ-024 stall SHALL be high only in cycle 1 of CALL/RET; single-word ops never stall.
REQ-025 In SECOND, op/req_valid inputs SHALL be ignored; the latched op completes.
REQ-026 req_valid=0 or op=NONE: no strobes, no state change; invalid op codes treated as NONE.
REQ-027 sp arithmetic SHALL be modulo 2^ADDR_SIZE.
REQ-028 rdata_valid/pc_valid SHALL be single-cycle pulses; rdata/pc_out hold last value.

Reset
REQ-029 rst SHALL force state=IDLE, sp=2^ADDR_SIZE-1, rdata=0, pc_out=0, all valids/stall/stack_err=0, strobes 0.
REQ-030 rst mid-CALL/RET SHALL abort: no pc_valid, sp not updated; rst dominates all inputs.

Configuration
REQ-031 With STACK_CHECK_EN defined: PUSH/CALL that would cross below address 0, or POP/RET that would cross above 2^ADDR_SIZE-1, SHALL suppress strobes, leave sp unchanged, set stack_err (sticky until rst), no valid pulse.
REQ-032 Without STACK_CHECK_EN: sp wraps silently, stack_err tied 0.

Structure
REQ-033 Package mem_pkg SHALL hold op enum, FSM state enum, SP_RESET constant.
REQ-034 Sub-module sp_unit SHALL hold the sp register with +1/-1/+2/-2 update and bound check.

Verification
REQ-035 Reset, PUSH 0xBEEF then POP -> mem[0x7FF]=0xBEEF, sp 0x7FF->0x7FE->0x7FF, rdata=0xBEEF with one-cycle rdata_valid.
REQ-036 CALL pc_in=0x12345678 -> stall one cycle, mem[0x7FF]=0x1234, mem[0x7FE]=0x5678, sp=0x7FD; RET -> pc_out=0x12345678, pc_valid one cycle, sp=0x7FF.
REQ-037 STORE ea=0x010 wdata=0xA5A5, then LOAD ea=0x010 -> rdata=0xA5A5, no stall.
REQ-038 rst asserted in CALL cycle 2 -> sp=0x7FF, state IDLE, no further writes.
REQ-039 Reset then POP: with STACK_CHECK_EN -> stack_err=1, sp=0x7FF, no mem_read; without -> sp wraps to 0x000, mem_read at 0x000.
